decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised successor to the combinational RV32I control unit. It decodes the full RV32I base set, including branches, loads, stores and JALR, and flags illegal encodings. Outputs sit behind one pipeline register with a valid/ready handshake, and the stage stalls on load-use hazards using a shift-register scoreboard. It sits between fetch and execute.

Parameters:
XLEN, 32, datapath/immediate width; only 32 supported, kept for port sizing.
REG_ADDR_W, 5, register index width; 4 selects RV32E (an rs1/rs2/rd MSB of 1 → illegal).
LOAD_LATENCY, 1, cycles after load issue during which its rd is unavailable; range 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  kill registered instruction (branch redirect)
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  registered PC
B, J, jalr  out  1 each  branch / JAL / JALR flags
ALUControl  out  5  ALU op (RV32I codes 0_xxxx as before; 1_0xxx reserved for M)
rs1, rs2, rd  out  REG_ADDR_W each  register selects
we, rf_we  out  1 each  memory write / regfile write
ALU_sel_A, ALU_sel_B  out  1 each  A: 0=rs1, 1=pc; B: 0=rs2, 1=imm
data_size  out  3  funct3 for loads/stores, else 0
WB_sel  out  1  0=ALU, 1=memory
imm  out  XLEN  sign-extended immediate
illegal  out  1  unsupported/illegal encoding

Behaviour:
- Reset: out_valid=0, all bundle outputs 0, scoreboard cleared. in_ready is combinational and is 1 once reset deasserts.
- ALU codes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 sll, 00110 srl, 00111 sra, 01000 slt, 01001 sltu, 01111 passB.
- OP-IMM, LUI, AUIPC, OP and JAL decode exactly as in the current control unit.
- OP with funct7 not in {0000000, 0100000} → illegal. OP-IMM shifts with bad funct7 → illegal.
- JALR: jalr=1, ALU_sel_A=1, ALUControl=add, I-imm, rf_we=1.
- BRANCH: B=1, ALU_sel_B=0, B-imm. beq/bne → sub; blt/bge → slt; bltu/bgeu → sltu; funct3 010/011 → illegal.
- LOAD: WB_sel=1, rf_we=1, ALU_sel_B=1, I-imm, add, data_size=funct3; funct3 ∈ {011,110,111} → illegal.
- STORE: we=1, rf_we=0, S-imm, add, data_size=funct3; funct3>010 → illegal.
- Unknown opcode, or instr[1:0]≠11 → illegal=1, we=0, rf_we=0, B=J=jalr=0, imm=0.
- rd==0 forces rf_we=0.
- Latency: one cycle. A bundle captured at edge N is visible after N while out_valid=1.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - Capture on in_valid && in_ready.
  - out_valid holds, and bundle is stable, while out_ready=0.
  - Simultaneous issue and capture: the new bundle replaces the old with no bubble.
- Scoreboard: LOAD_LATENCY-entry shift register of {v, rd}, shifted every cycle with v=0 entering. On issue (out_valid && out_ready) of a load with rd≠0, the new {1, rd} is inserted at the head in the same shift.
- Hazard: in_valid and the incoming instruction reads rs1 or rs2 (by opcode; LUI/AUIPC/JAL read none), the register is nonzero, and it matches any valid entry or the currently registered load's rd.
- flush: next cycle out_valid=0 and the capture that cycle is suppressed; flush wins over in_valid. Scoreboard is unaffected, since issued loads still complete.
- rst mid-operation: discards the registered bundle and scoreboard in the same edge.

Optional Feature:
MYRV_MEXT_EN:
- Defined: OP with funct7=0000001 decodes RV32M. mul..remu map to ALUControl 1_0000..1_0111 in funct3 order; rf_we=1.
- Undefined: that encoding → illegal=1.

Test Plan:
- addi x5,x1,-3 (0xFFD08293), out_ready=1 → next cycle out_valid=1, rd=5, imm=0xFFFFFFFD, ALUControl=00000, ALU_sel_B=1, rf_we=1.
- lw x6,0(x2) then add x7,x6,x1 back-to-back, LOAD_LATENCY=1 → add held with in_ready=0 for 2 cycles after lw captured, then issues; inserting add x7,x3,x1 instead → no stall.
- out_ready=0 for 3 cycles with bundle bne x1,x2,+8 → outputs stable; B=1, ALUControl=00001, imm=8; in_ready=0 throughout.
- flush asserted together with in_valid → out_valid=0 next cycle, instruction not captured.
- 0x00000000, and sub with funct7=0100001 → illegal=1, we=0, rf_we=0; mul x1,x2,x3 → illegal=1 without MYRV_MEXT_EN, ALUControl=10000 with it.
- addi x0,x0,1 → rf_we=0. rst pulse while out_valid=1 → out_valid=0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with load-use stall; RV32M decode enabled by MYRV_MEXT_EN
module decode_stage #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic                  B,
   output logic                  J,
   output logic                  jalr,
   output logic [4:0]            ALUControl,
   output logic [REG_ADDR_W-1:0] rs1,
   output logic [REG_ADDR_W-1:0] rs2,
   output logic [REG_ADDR_W-1:0] rd,
   output logic                  we,
   output logic                  rf_we,
   output logic                  ALU_sel_A,
   output logic                  ALU_sel_B,
   output logic [2:0]            data_size,
   output logic                  WB_sel,
   output logic [XLEN-1:0]       imm,
   output logic                  illegal
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00011;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_SLL  = 5'b00101;
   localparam logic [4:0] ALU_SRL  = 5'b00110;
   localparam logic [4:0] ALU_SRA  = 5'b00111;
   localparam logic [4:0] ALU_SLT  = 5'b01000;
   localparam logic [4:0] ALU_SLTU = 5'b01001;
   localparam logic [4:0] ALU_PASS = 5'b01111;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] f_rs1, f_rs2, f_rd;
   logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign f_rd   = in_instr[7 +: REG_ADDR_W];
   assign f_rs1  = in_instr[15 +: REG_ADDR_W];
   assign f_rs2  = in_instr[20 +: REG_ADDR_W];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   logic                  d_B, d_J, d_jalr, d_we, d_rf_we, d_sel_a, d_sel_b, d_wb, d_ill;
   logic [4:0]            d_alu;
   logic [2:0]            d_size;
   logic [XLEN-1:0]       d_imm;
   logic [REG_ADDR_W-1:0] d_rs1, d_rs2, d_rd;
   logic                  uses_rs1, uses_rs2, uses_rd;

   // Decode the offered instruction into a bundle; any illegal encoding collapses to an inert bundle
   always_comb begin
      d_B = 1'b0; d_J = 1'b0; d_jalr = 1'b0; d_we = 1'b0; d_rf_we = 1'b0;
      d_sel_a = 1'b0; d_sel_b = 1'b0; d_wb = 1'b0; d_ill = 1'b0;
      d_alu = ALU_ADD; d_size = 3'b000; d_imm = '0;
      d_rs1 = '0; d_rs2 = '0; d_rd = '0;
      uses_rs1 = 1'b0; uses_rs2 = 1'b0; uses_rd = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            uses_rs1 = 1'b1; uses_rd = 1'b1;
            d_rf_we = 1'b1; d_sel_b = 1'b1; d_imm = imm_i;
            case (funct3)
               3'b000:  d_alu = ALU_ADD;
               3'b010:  d_alu = ALU_SLT;
               3'b011:  d_alu = ALU_SLTU;
               3'b100:  d_alu = ALU_XOR;
               3'b110:  d_alu = ALU_OR;
               3'b111:  d_alu = ALU_AND;
               3'b001: begin
                  d_alu = ALU_SLL;
                  d_ill = (funct7 != 7'b0000000);
               end
               default: begin
                  if (funct7 == 7'b0000000)      d_alu = ALU_SRL;
                  else if (funct7 == 7'b0100000) d_alu = ALU_SRA;
                  else                           d_ill = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            uses_rd = 1'b1;
            d_rf_we = 1'b1; d_sel_b = 1'b1; d_alu = ALU_PASS; d_imm = imm_u;
         end
         OPC_AUIPC: begin
            uses_rd = 1'b1;
            d_rf_we = 1'b1; d_sel_a = 1'b1; d_sel_b = 1'b1; d_imm = imm_u;
         end
         OPC_OP: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
            d_rf_we = 1'b1;
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'b000:  d_alu = ALU_ADD;
                     3'b001:  d_alu = ALU_SLL;
                     3'b010:  d_alu = ALU_SLT;
                     3'b011:  d_alu = ALU_SLTU;
                     3'b100:  d_alu = ALU_XOR;
                     3'b101:  d_alu = ALU_SRL;
                     3'b110:  d_alu = ALU_OR;
                     default: d_alu = ALU_AND;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'b000)      d_alu = ALU_SUB;
                  else if (funct3 == 3'b101) d_alu = ALU_SRA;
                  else                       d_ill = 1'b1;
               end
`ifdef MYRV_MEXT_EN
               7'b0000001: d_alu = {2'b10, funct3};
`endif
               default: d_ill = 1'b1;
            endcase
         end
         OPC_JAL: begin
            uses_rd = 1'b1;
            d_J = 1'b1; d_rf_we = 1'b1; d_sel_a = 1'b1; d_sel_b = 1'b1; d_imm = imm_j;
         end
         OPC_JALR: begin
            uses_rs1 = 1'b1; uses_rd = 1'b1;
            d_jalr = 1'b1; d_rf_we = 1'b1; d_sel_a = 1'b1; d_sel_b = 1'b1; d_imm = imm_i;
            d_ill = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            d_B = 1'b1; d_imm = imm_b;
            case (funct3)
               3'b000, 3'b001: d_alu = ALU_SUB;
               3'b100, 3'b101: d_alu = ALU_SLT;
               3'b110, 3'b111: d_alu = ALU_SLTU;
               default:        d_ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            uses_rs1 = 1'b1; uses_rd = 1'b1;
            d_wb = 1'b1; d_rf_we = 1'b1; d_sel_b = 1'b1; d_imm = imm_i; d_size = funct3;
            d_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            d_we = 1'b1; d_sel_b = 1'b1; d_imm = imm_s; d_size = funct3;
            d_ill = (funct3 > 3'b010);
         end
         default: d_ill = 1'b1;
      endcase

      // RV32E build: register fields reaching x16..x31 do not exist
      if (REG_ADDR_W < 5)
         if ((uses_rs1 && in_instr[19]) || (uses_rs2 && in_instr[24]) || (uses_rd && in_instr[11]))
            d_ill = 1'b1;
      if (in_instr[1:0] != 2'b11)
         d_ill = 1'b1;

      if (d_ill) begin
         d_B = 1'b0; d_J = 1'b0; d_jalr = 1'b0; d_we = 1'b0; d_rf_we = 1'b0;
         d_sel_a = 1'b0; d_sel_b = 1'b0; d_wb = 1'b0;
         d_alu = ALU_ADD; d_size = 3'b000; d_imm = '0;
      end else begin
         d_rs1 = f_rs1;
         d_rs2 = f_rs2;
         d_rd  = f_rd;
         if (f_rd == '0)
            d_rf_we = 1'b0;
      end
   end

   logic [LOAD_LATENCY-1:0] sb_v;
   logic [REG_ADDR_W-1:0]   sb_rd [LOAD_LATENCY];
   logic                    rs1_busy, rs2_busy, hazard;
   logic                    capture, issue, load_issue;

   // Load-use check against the registered load and every load still in flight
   always_comb begin
      rs1_busy = out_valid && WB_sel && (rd == f_rs1);
      rs2_busy = out_valid && WB_sel && (rd == f_rs2);
      for (int i = 0; i < LOAD_LATENCY; i++) begin
         rs1_busy = rs1_busy || (sb_v[i] && (sb_rd[i] == f_rs1));
         rs2_busy = rs2_busy || (sb_v[i] && (sb_rd[i] == f_rs2));
      end
      hazard = in_valid && ((uses_rs1 && (f_rs1 != '0) && rs1_busy) ||
                            (uses_rs2 && (f_rs2 != '0) && rs2_busy));
   end

   assign in_ready   = (!out_valid || out_ready) && !hazard;
   assign capture    = in_valid && in_ready && !flush;
   assign issue      = out_valid && out_ready;
   assign load_issue = issue && WB_sel && (rd != '0);

   // Output pipeline register: flush kills, capture replaces, issue without capture drains
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pc <= '0; B <= 1'b0; J <= 1'b0; jalr <= 1'b0; ALUControl <= '0;
         rs1 <= '0; rs2 <= '0; rd <= '0; we <= 1'b0; rf_we <= 1'b0;
         ALU_sel_A <= 1'b0; ALU_sel_B <= 1'b0; data_size <= '0; WB_sel <= 1'b0;
         imm <= '0; illegal <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (capture)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         if (capture) begin
            out_pc <= in_pc; B <= d_B; J <= d_J; jalr <= d_jalr; ALUControl <= d_alu;
            rs1 <= d_rs1; rs2 <= d_rs2; rd <= d_rd; we <= d_we; rf_we <= d_rf_we;
            ALU_sel_A <= d_sel_a; ALU_sel_B <= d_sel_b; data_size <= d_size; WB_sel <= d_wb;
            imm <= d_imm; illegal <= d_ill;
         end
      end
   end

   // In-flight load tracker: ages every cycle, newly issued load enters at the head
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_v <= '0;
         for (int i = 0; i < LOAD_LATENCY; i++)
            sb_rd[i] <= '0;
      end else begin
         for (int i = LOAD_LATENCY - 1; i > 0; i--) begin
            sb_v[i]  <= sb_v[i-1];
            sb_rd[i] <= sb_rd[i-1];
         end
         sb_v[0]  <= load_issue;
         sb_rd[0] <= load_issue ? rd : '0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a reference decoder and hazard model
module tb_decode_stage;

   localparam int LAT = 1;

   localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_AND = 5'd2, A_OR = 5'd3, A_XOR = 5'd4;
   localparam logic [4:0] A_SLL = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_SLT = 5'd8, A_SLTU = 5'd9;
   localparam logic [4:0] A_PASSB = 5'd15;

   localparam logic [31:0] I_ADDI   = 32'hFFD08293;
   localparam logic [31:0] I_LW     = 32'h00012303;
   localparam logic [31:0] I_ADD76  = 32'h001303B3;
   localparam logic [31:0] I_ADD73  = 32'h001183B3;
   localparam logic [31:0] I_BNE    = 32'h00209463;
   localparam logic [31:0] I_SUBBAD = 32'h423100B3;
   localparam logic [31:0] I_MUL    = 32'h023100B3;
   localparam logic [31:0] I_ADDI0  = 32'h00100013;

   typedef struct packed {
      logic        B, J, jalr;
      logic [4:0]  alu;
      logic [4:0]  rs1, rs2, rd;
      logic        we, rf_we, sa, sb;
      logic [2:0]  ds;
      logic        wb;
      logic [31:0] imm;
      logic        ill;
      logic [31:0] pc;
   } bundle_t;

   typedef struct {
      logic [4:0] rd;
      int         t;
   } ld_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_instr = '0, in_pc = '0;
   logic        flush = 1'b0, out_valid, out_ready = 1'b0;
   logic [31:0] out_pc, imm;
   logic        B, J, jalr, we, rf_we, ALU_sel_A, ALU_sel_B, WB_sel, illegal;
   logic [4:0]  ALUControl, rs1, rs2, rd;
   logic [2:0]  data_size;

   decode_stage #(.XLEN(32), .REG_ADDR_W(5), .LOAD_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .B(B), .J(J), .jalr(jalr), .ALUControl(ALUControl), .rs1(rs1), .rs2(rs2), .rd(rd),
      .we(we), .rf_we(rf_we), .ALU_sel_A(ALU_sel_A), .ALU_sel_B(ALU_sel_B),
      .data_size(data_size), .WB_sel(WB_sel), .imm(imm), .illegal(illegal)
   );

   always #5 clk = ~clk;

   bundle_t dut_b;
   assign dut_b = {B, J, jalr, ALUControl, rs1, rs2, rd, we, rf_we, ALU_sel_A, ALU_sel_B,
                   data_size, WB_sel, imm, illegal, out_pc};

   int          n_checks = 0, n_fail = 0;
   int          cyc = 0;
   bundle_t     exp_q[$];
   ld_t         busy[$];
   logic        m_valid = 1'b0;
   logic [4:0]  m_load_rd = '0;
   logic        m_cap = 1'b0;
   logic        last_rdy = 1'b0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decoder: instruction rules written out per format, immediates by arithmetic
   function automatic bundle_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
      bundle_t    e;
      logic       ok;
      logic [2:0] f3;
      logic [6:0] f7;
      int         ii, bi, ji, si;
      e  = '0;
      ok = (w[1:0] == 2'b11);
      f3 = w[14:12];
      f7 = w[31:25];
      ii = $signed(w) >>> 20;
      si = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      bi = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      ji = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      case (w[6:0])
         7'h13: begin
            e.sb = 1; e.rf_we = 1; e.imm = ii;
            case (f3)
               3'd0: e.alu = A_ADD;
               3'd2: e.alu = A_SLT;
               3'd3: e.alu = A_SLTU;
               3'd4: e.alu = A_XOR;
               3'd6: e.alu = A_OR;
               3'd7: e.alu = A_AND;
               3'd1: begin e.alu = A_SLL; if (f7 != 0) ok = 0; end
               default: begin
                  if (f7 == 7'h00) e.alu = A_SRL;
                  else if (f7 == 7'h20) e.alu = A_SRA;
                  else ok = 0;
               end
            endcase
         end
         7'h37: begin e.rf_we = 1; e.sb = 1; e.alu = A_PASSB; e.imm = w & 32'hFFFFF000; end
         7'h17: begin e.rf_we = 1; e.sa = 1; e.sb = 1; e.alu = A_ADD; e.imm = w & 32'hFFFFF000; end
         7'h33: begin
            e.rf_we = 1;
            case ({f7, f3})
               {7'h00, 3'd0}: e.alu = A_ADD;
               {7'h20, 3'd0}: e.alu = A_SUB;
               {7'h00, 3'd1}: e.alu = A_SLL;
               {7'h00, 3'd2}: e.alu = A_SLT;
               {7'h00, 3'd3}: e.alu = A_SLTU;
               {7'h00, 3'd4}: e.alu = A_XOR;
               {7'h00, 3'd5}: e.alu = A_SRL;
               {7'h20, 3'd5}: e.alu = A_SRA;
               {7'h00, 3'd6}: e.alu = A_OR;
               {7'h00, 3'd7}: e.alu = A_AND;
               default: begin
`ifdef MYRV_MEXT_EN
                  if (f7 == 7'h01) e.alu = 5'd16 + 5'(f3);
                  else ok = 0;
`else
                  ok = 0;
`endif
               end
            endcase
         end
         7'h6F: begin e.J = 1; e.rf_we = 1; e.sa = 1; e.sb = 1; e.alu = A_ADD; e.imm = ji; end
         7'h67: begin e.jalr = 1; e.rf_we = 1; e.sa = 1; e.sb = 1; e.alu = A_ADD; e.imm = ii; if (f3 != 0) ok = 0; end
         7'h63: begin
            e.B = 1; e.imm = bi;
            if (f3 == 3'd2 || f3 == 3'd3) ok = 0;
            else if (f3 < 3'd2) e.alu = A_SUB;
            else if (f3 < 3'd6) e.alu = A_SLT;
            else e.alu = A_SLTU;
         end
         7'h03: begin
            e.wb = 1; e.rf_we = 1; e.sb = 1; e.alu = A_ADD; e.imm = ii; e.ds = f3;
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ok = 0;
         end
         7'h23: begin e.we = 1; e.sb = 1; e.alu = A_ADD; e.imm = si; e.ds = f3; if (f3 > 3'd2) ok = 0; end
         default: ok = 0;
      endcase
      if (!ok) begin
         e = '0;
         e.ill = 1;
      end else begin
         e.rs1 = w[19:15];
         e.rs2 = w[24:20];
         e.rd  = w[11:7];
         if (e.rd == 0) e.rf_we = 0;
      end
      e.pc = pc;
      return e;
   endfunction

   function automatic logic reg_busy(input logic [4:0] r);
      if (r == 0) return 1'b0;
      if (m_valid && m_load_rd == r) return 1'b1;
      foreach (busy[i])
         if (busy[i].rd == r && (cyc - busy[i].t) < LAT) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic model_hazard(input logic [31:0] w);
      logic r1, r2;
      r1 = (w[6:0] == 7'h33 || w[6:0] == 7'h23 || w[6:0] == 7'h63 ||
            w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h67);
      r2 = (w[6:0] == 7'h33 || w[6:0] == 7'h23 || w[6:0] == 7'h63);
      return (r1 && reg_busy(w[19:15])) || (r2 && reg_busy(w[24:20]));
   endfunction

   // One bench cycle: drive at negedge, check handshake, advance the model to the coming edge
   task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl, input logic r);
      logic    exp_rdy, iss;
      bundle_t e;
      @(negedge clk);
      rst = r; in_valid = v; in_instr = w; in_pc = pc_ctr; out_ready = ordy; flush = fl;
      #1;
      exp_rdy = (!m_valid || ordy) && !(v && model_hazard(w));
      last_rdy = in_ready;
      m_cap = 1'b0;
      if (!r) begin
         chk("out_valid", out_valid, m_valid);
         chk("in_ready", in_ready, exp_rdy);
      end
      if (r) begin
         m_valid = 0;
         busy.delete();
         exp_q.delete();
      end else begin
         iss = m_valid && ordy;
         if (iss && m_load_rd != 0) busy.push_back('{m_load_rd, cyc + 1});
         while (busy.size() > 0 && (cyc + 1 - busy[0].t) >= LAT) void'(busy.pop_front());
         m_cap = v && exp_rdy && !fl;
         if (fl) m_valid = 0;
         else if (m_cap) begin
            e = ref_dec(w, pc_ctr);
            m_valid = 1;
            m_load_rd = e.wb ? e.rd : 5'd0;
            exp_q.push_back(e);
            pc_ctr += 4;
         end else if (ordy) m_valid = 0;
      end
   endtask

   // Monitor: compare the presented bundle with the oldest expected one; retire it on issue or flush
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst && out_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("bundle_unexpected", 1, 0);
            else begin
               chk("bundle", dut_b, exp_q[0]);
               if (out_ready || flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] gen();
      logic [31:0] w;
      logic [6:0]  ops [10];
      int          k;
      ops = '{7'h13, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h03};
      w = $urandom;
      k = $urandom_range(0, 10);
      if (k < 10) w[6:0] = ops[k];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
         0, 1, 2: w[31:25] = 7'h00;
         3:       w[31:25] = 7'h20;
         4:       w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      int          stalls;
      logic        have;
      logic        v, fl;
      logic [31:0] w;

      cycle(0, 0, 1, 0, 1);
      cycle(0, 0, 1, 0, 1);
      @(posedge clk); #1;
      chk("reset_bundle", dut_b, '0);
      chk("reset_out_valid", out_valid, 0);

      cycle(1, I_ADDI, 1, 0, 0);
      @(posedge clk); #1;
      chk("addi_valid", out_valid, 1);
      chk("addi_rd", rd, 5);
      chk("addi_imm", imm, 32'hFFFFFFFD);
      chk("addi_alu", ALUControl, A_ADD);
      chk("addi_selb", ALU_sel_B, 1);
      chk("addi_rfwe", rf_we, 1);
      cycle(0, 0, 1, 0, 0);

      cycle(1, I_LW, 1, 0, 0);
      stalls = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(1, I_ADD76, 1, 0, 0);
         if (last_rdy === 1'b1) break;
         stalls++;
      end
      chk("load_use_stall_cycles", stalls, 2);
      repeat (4) cycle(0, 0, 1, 0, 0);

      cycle(1, I_LW, 1, 0, 0);
      cycle(1, I_ADD73, 1, 0, 0);
      chk("independent_no_stall", last_rdy, 1);
      repeat (3) cycle(0, 0, 1, 0, 0);

      cycle(1, I_BNE, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle(1, I_ADDI, 0, 0, 0);
         @(posedge clk); #1;
         chk("bne_B", B, 1);
         chk("bne_alu", ALUControl, A_SUB);
         chk("bne_imm", imm, 8);
      end
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);

      cycle(1, I_ADDI, 1, 1, 0);
      @(posedge clk); #1;
      chk("flush_no_capture", out_valid, 0);

      cycle(1, 32'h0, 1, 0, 0);
      cycle(1, I_SUBBAD, 1, 0, 0);
      cycle(1, I_MUL, 1, 0, 0);
      @(posedge clk); #1;
`ifdef MYRV_MEXT_EN
      chk("mul_alu", ALUControl, 5'b10000);
      chk("mul_illegal", illegal, 0);
`else
      chk("mul_illegal", illegal, 1);
`endif
      cycle(1, I_ADDI0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);

      cycle(1, I_ADDI, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      @(posedge clk); #1;
      chk("rst_mid_valid", out_valid, 0);

      have = 0;
      w = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!have) begin
            w = gen();
            have = 1;
         end
         v  = ($urandom_range(0, 4) != 0);
         fl = ($urandom_range(0, 19) == 0);
         cycle(v, w, ($urandom_range(0, 3) != 0), fl, ($urandom_range(0, 499) == 0));
         if (m_cap || (v && fl)) have = 0;
      end
      repeat (3) cycle(0, 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
